bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared two-CPU coherence bus.
- Accepts miss/invalidate requests from cpu0 and cpu1 and grants the bus to exactly one of them.
- Latches the winner's operation and address, and holds ownership until the coherence controller signals completion or a timeout fires.
- Inserts one release cycle between transactions. Sits between the CPU cache controllers and the bus coherence FSM.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles in ACTIVE before forced release.
- MIN_HOLD, 2: minimum cycles in ACTIVE before txn_done is honoured; guarantees forwarded data is stable for at least 2 cycles.
- CNT_W, 4: hold-counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset. Synchronous, active-low; sampled on rising clk edge.
- req_0  input  1  cpu0 requests the bus
- op_0  input  2  cpu0 request type (bus_req_t)
- addr_0  input  11  cpu0 full address
- req_1  input  1  cpu1 requests the bus
- op_1  input  2  cpu1 request type (bus_req_t)
- addr_1  input  11  cpu1 full address
- txn_done  input  1  coherence controller finished the current transaction
- grant_0  output  1  cpu0 owns the bus
- grant_1  output  1  cpu1 owns the bus
- bus_valid  output  1  bus_op/bus_addr describe a live transaction
- bus_op  output  2  latched operation of the owner
- bus_addr  output  11  latched address of the owner
- owner  output  1  0 = cpu0, 1 = cpu1; valid only when bus_valid = 1
- timeout  output  1  one-cycle pulse when a transaction is force-released

Behaviour:
- All outputs are registered.
- Reset values (rst_n = 0 at a rising edge):
  - state = IDLE; grant_0 = grant_1 = 0; bus_valid = 0; bus_op = 2'b00; bus_addr = 0; owner = 0; timeout = 0; hold counter = 0.
  - last_owner = 1, so cpu0 wins the first tie.
  - Reset asserted mid-transaction aborts it. No timeout pulse is produced.
- A request is eligible when req_x = 1 and op_x != 2'b11. An op of 2'b11 is never granted and does not block the other CPU.
- IDLE:
  - No eligible request: stay in IDLE.
  - One eligible request: that CPU wins.
  - Both eligible: the CPU != last_owner wins.
  - On the edge that selects a winner: go to ACTIVE; set grant_w = 1, bus_valid = 1, owner = w; latch bus_op = op_w and bus_addr = addr_w; clear the counter.
  - Latency: request sampled at edge N produces grant visible after edge N.
- ACTIVE:
  - Counter increments every cycle. Saturates; it never wraps.
  - Grant, bus_op and bus_addr are frozen; changes on req/op/addr are ignored. Owner dropping req mid-transaction does not release the bus.
  - txn_done is ignored while counter < MIN_HOLD-1.
  - If txn_done = 1 and counter >= MIN_HOLD-1: go to RELEASE.
  - Else if counter == TIMEOUT_CYCLES-1: go to RELEASE and set timeout = 1 for the RELEASE cycle only.
  - If txn_done and the timeout condition coincide, txn_done wins; no timeout pulse.
- RELEASE:
  - grant_0 = grant_1 = 0 and bus_valid = 0 for exactly one cycle.
  - last_owner = owner.
  - Next state is IDLE unconditionally.
  - Back-to-back requests from one CPU therefore see a 2-cycle gap between grants.
- Invariant: grant_0 & grant_1 == 0 in every cycle.
- txn_done asserted while in IDLE or RELEASE is ignored.

Decomposition:
- Shared package common holds:
  - bus_req_t enum {REQ_READ_MISS = 2'b00, REQ_WRITE_MISS = 2'b01, REQ_INVALIDATE = 2'b10}; 2'b11 is reserved.
  - arb_state_t enum {ARB_IDLE, ARB_ACTIVE, ARB_RELEASE}.
- One sub-module, arb_hold_timer: saturating CNT_W counter with sync clear. Provides min_hold_met and expired flags, parameterised by MIN_HOLD and TIMEOUT_CYCLES.
- Round-robin select and FSM stay in bus_arbiter.

Test Plan:
- Reset, then req_0 = 1, op_0 = 2'b00, addr_0 = 11'h123 for one cycle → next cycle grant_0 = 1, bus_valid = 1, bus_op = 00, bus_addr = 11'h123, owner = 0.
- req_0 and req_1 both held from reset → grant order cpu0, cpu1, cpu0. Each grant is separated by one RELEASE cycle with both grants = 0.
- cpu1 owns the bus and txn_done pulses on the first ACTIVE cycle → ignored. txn_done on the second ACTIVE cycle → release. Grant lasts exactly 2 cycles.
- Owner granted and txn_done never asserted → grant held 15 cycles, then timeout = 1 for 1 cycle with grants 0, then IDLE.
- op_0 = 2'b11 with req_0 = 1, and req_1 = 1 with op_1 = 2'b10 → cpu1 granted; cpu0 is never granted while op_0 = 11.
- rst_n = 0 during ACTIVE (counter = 5) → next edge all outputs at reset values, timeout = 0. A subsequent cpu0/cpu1 tie grants cpu0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared request/state types for the two-CPU coherence bus arbiter.
// Holds the bus request encoding, arbiter FSM states and the reserved-op constant.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        REQ_READ_MISS  = 2'b00,
        REQ_WRITE_MISS = 2'b01,
        REQ_INVALIDATE = 2'b10
    } bus_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACTIVE,
        ARB_RELEASE
    } arb_state_t;

    // 2'b11 is not a legal bus_req_t; such requests are never granted.
    localparam logic [1:0] OP_RESERVED = 2'b11;

endpackage

// File: rtl/arb_hold_timer.sv
// arb_hold_timer: saturating hold counter with synchronous clear for bus ownership.
// Ports: clk_i clock; rst_ni sync active-low reset; clr_i sync clear;
//        min_hold_met_o count reached MIN_HOLD-1; expired_o count equals TIMEOUT_CYCLES-1.
module arb_hold_timer #(
    parameter int CNT_W          = 4,
    parameter int MIN_HOLD       = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic min_hold_met_o,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at all-ones so a stalled owner can never wrap back below MIN_HOLD.
    always_comb cnt_d = clr_i ? '0 : (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign min_hold_met_o = cnt_q >= CNT_W'(MIN_HOLD - 1);
    assign expired_o      = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and transaction sequencer for the two-CPU coherence bus.
// Ports: clk_i/rst_ni clock and sync active-low reset; req/op/addr_{0,1}_i CPU requests;
//        txn_done_i completion from coherence controller; grant_{0,1}_o bus ownership;
//        bus_valid_o/bus_op_o/bus_addr_o/owner_o latched live transaction; timeout_o forced-release pulse.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int MIN_HOLD       = 2,
    parameter int CNT_W          = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_0_i,
    input  logic [1:0]  op_0_i,
    input  logic [10:0] addr_0_i,
    input  logic        req_1_i,
    input  logic [1:0]  op_1_i,
    input  logic [10:0] addr_1_i,
    input  logic        txn_done_i,
    output logic        grant_0_o,
    output logic        grant_1_o,
    output logic        bus_valid_o,
    output logic [1:0]  bus_op_o,
    output logic [10:0] bus_addr_o,
    output logic        owner_o,
    output logic        timeout_o
);

    arb_state_t  state_q, state_d;
    logic        grant_0_q, grant_0_d, grant_1_q, grant_1_d;
    logic        bus_valid_q, bus_valid_d, owner_q, owner_d;
    logic        timeout_q, timeout_d, last_owner_q, last_owner_d;
    logic [1:0]  bus_op_q, bus_op_d;
    logic [10:0] bus_addr_q, bus_addr_d;
    logic        elig_0, elig_1, win_1, min_hold_met, expired, done_ok;

    assign elig_0  = req_0_i && (op_0_i != OP_RESERVED);
    assign elig_1  = req_1_i && (op_1_i != OP_RESERVED);
    // On a tie the CPU that did not own the bus last time wins.
    assign win_1   = elig_1 && (!elig_0 || !last_owner_q);
    assign done_ok = txn_done_i && min_hold_met;

    arb_hold_timer #(
        .CNT_W(CNT_W), .MIN_HOLD(MIN_HOLD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(state_q != ARB_ACTIVE),
        .min_hold_met_o(min_hold_met), .expired_o(expired)
    );

    always_comb begin
        state_d      = state_q;
        grant_0_d    = grant_0_q;
        grant_1_d    = grant_1_q;
        bus_valid_d  = bus_valid_q;
        bus_op_d     = bus_op_q;
        bus_addr_d   = bus_addr_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        timeout_d    = 1'b0;
        case (state_q)
            ARB_IDLE: if (elig_0 || elig_1) begin
                state_d     = ARB_ACTIVE;
                grant_0_d   = !win_1;
                grant_1_d   = win_1;
                bus_valid_d = 1'b1;
                owner_d     = win_1;
                bus_op_d    = win_1 ? op_1_i : op_0_i;
                bus_addr_d  = win_1 ? addr_1_i : addr_0_i;
            end
            ARB_ACTIVE: if (done_ok || expired) begin
                state_d      = ARB_RELEASE;
                grant_0_d    = 1'b0;
                grant_1_d    = 1'b0;
                bus_valid_d  = 1'b0;
                last_owner_d = owner_q;
                // A completion arriving on the timeout cycle wins: no pulse.
                timeout_d    = !done_ok;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            grant_0_q    <= 1'b0;
            grant_1_q    <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_op_q     <= 2'b00;
            bus_addr_q   <= '0;
            owner_q      <= 1'b0;
            timeout_q    <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_0_q    <= grant_0_d;
            grant_1_q    <= grant_1_d;
            bus_valid_q  <= bus_valid_d;
            bus_op_q     <= bus_op_d;
            bus_addr_q   <= bus_addr_d;
            owner_q      <= owner_d;
            timeout_q    <= timeout_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant_0_o   = grant_0_q;
    assign grant_1_o   = grant_1_q;
    assign bus_valid_o = bus_valid_q;
    assign bus_op_o    = bus_op_q;
    assign bus_addr_o  = bus_addr_q;
    assign owner_o     = owner_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized scoreboard bench for bus_arbiter with a transaction-level model.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_0 = 1'b0, req_1 = 1'b0, txn_done = 1'b0;
    logic [1:0]  op_0 = '0, op_1 = '0;
    logic [10:0] addr_0 = '0, addr_1 = '0;
    logic        grant_0, grant_1, bus_valid, owner, timeout;
    logic [1:0]  bus_op;
    logic [10:0] bus_addr;

    bus_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_0_i(req_0), .op_0_i(op_0), .addr_0_i(addr_0),
        .req_1_i(req_1), .op_1_i(op_1), .addr_1_i(addr_1),
        .txn_done_i(txn_done),
        .grant_0_o(grant_0), .grant_1_o(grant_1), .bus_valid_o(bus_valid),
        .bus_op_o(bus_op), .bus_addr_o(bus_addr), .owner_o(owner), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          own;
        logic [1:0]  op;
        logic [10:0] addr;
        int          len;
        bit          to;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    bit   last_w = 1'b1;
    int   idle_cnt = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected transaction when a grant appears and checks it to the end.
    exp_t cur;
    bit   prev_v = 1'b0, pend_rst = 1'b0;
    int   run = 0, zeros = 0;
    always @(negedge clk) begin
        if (!rst_n) pend_rst = 1'b1;
        else if (pend_rst) begin
            pend_rst = 1'b0;
            chk("reset_outs", {grant_0, grant_1, bus_valid, bus_op, bus_addr, owner, timeout}, '0);
            exp_q.delete();
            prev_v = 1'b0;
            zeros  = 1;
        end else begin
            chk("one_hot", {31'd0, grant_0 & grant_1}, 0);
            if (bus_valid && !prev_v) begin
                if (exp_q.size() == 0) chk("unexpected_grant", 1, 0);
                else begin
                    cur = exp_q.pop_front();
                    chk("owner", {31'd0, owner}, {31'd0, cur.own});
                    chk("grant", {30'd0, grant_1, grant_0}, cur.own ? 2 : 1);
                    chk("op_addr", {bus_op, bus_addr}, {cur.op, cur.addr});
                    if (cur.gap >= 0) chk("gap", zeros, cur.gap);
                end
                run = 1;
            end else if (bus_valid) begin
                run++;
                chk("frozen", {grant_1, grant_0, owner, bus_op, bus_addr},
                    {cur.own, !cur.own, cur.own, cur.op, cur.addr});
            end else if (prev_v) begin
                chk("hold_len", run, cur.len);
                chk("timeout", {31'd0, timeout}, {31'd0, cur.to});
                chk("release_grants", {grant_0, grant_1}, 0);
                zeros = 1;
            end else begin
                chk("no_timeout", {31'd0, timeout}, 0);
                zeros++;
            end
            prev_v = bus_valid;
        end
    end

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic junk;
        req_0 = 1'($urandom); req_1 = 1'($urandom);
        op_0 = 2'($urandom); op_1 = 2'($urandom);
        addr_0 = 11'($urandom); addr_1 = 11'($urandom);
    endtask

    // One IDLE cycle with the given requests; on a grant, run it through RELEASE.
    // d: active-cycle index of the txn_done pulse; z: extra pulse on the first active cycle.
    task automatic txn(input bit r0, input logic [1:0] o0, input logic [10:0] a0,
                       input bit r1, input logic [1:0] o1, input logic [10:0] a1,
                       input int d, input bit z);
        bit e0, e1, w;
        exp_t e;
        req_0 = r0; op_0 = o0; addr_0 = a0;
        req_1 = r1; op_1 = o1; addr_1 = a1;
        txn_done = 1'($urandom);
        edge1();
        if (idle_cnt >= 0) idle_cnt++;
        e0 = r0 && o0 != 2'b11;
        e1 = r1 && o1 != 2'b11;
        if (!(e0 || e1)) return;
        w = (e0 && e1) ? !last_w : e1;
        last_w = w;
        e.own = w; e.op = w ? o1 : o0; e.addr = w ? a1 : a0;
        e.to  = !(d >= 1 && d <= 14);
        e.len = e.to ? 15 : d + 1;
        e.gap = idle_cnt;
        exp_q.push_back(e);
        for (int i = 0; i < e.len; i++) begin
            junk();
            txn_done = (i == d) || (i == 0 && z);
            edge1();
        end
        junk();
        txn_done = 1'($urandom);
        edge1();
        idle_cnt = 1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        edge1();
        rst_n = 1'b1;
        last_w = 1'b1;
        idle_cnt = -1;
    endtask

    initial begin
        edge1();
        do_reset();
        txn(1, 2'b00, 11'h123, 0, 2'b00, 11'h000, 3, 0);
        txn(1, 2'b01, 11'h010, 1, 2'b10, 11'h020, 1, 0);
        txn(1, 2'b01, 11'h011, 1, 2'b10, 11'h021, 2, 0);
        txn(1, 2'b00, 11'h012, 1, 2'b00, 11'h022, 1, 1);
        txn(0, 2'b00, 11'h000, 1, 2'b01, 11'h7ff, 1, 1);
        txn(0, 2'b00, 11'h000, 1, 2'b00, 11'h055, 99, 0);
        txn(1, 2'b00, 11'h056, 0, 2'b00, 11'h000, 14, 0);
        txn(1, 2'b11, 11'h0aa, 1, 2'b10, 11'h0bb, 2, 0);
        txn(1, 2'b11, 11'h0ab, 0, 2'b10, 11'h0bc, 2, 0);
        txn(1, 2'b11, 11'h0ac, 1, 2'b10, 11'h0bd, 2, 0);
        // Abort a transaction mid-flight with the counter at 5.
        txn(0, 2'b00, 11'h000, 0, 2'b00, 11'h000, 0, 0);
        req_0 = 1; op_0 = 2'b01; addr_0 = 11'h3c3;
        req_1 = 1; op_1 = 2'b00; addr_1 = 11'h5a5;
        edge1();
        exp_q.push_back('{own: !last_w, op: last_w ? 2'b01 : 2'b00,
                          addr: last_w ? 11'h3c3 : 11'h5a5, len: 0, to: 0, gap: -1});
        for (int i = 0; i < 5; i++) begin
            txn_done = 1'b0;
            edge1();
        end
        do_reset();
        txn(1, 2'b10, 11'h111, 1, 2'b01, 11'h222, 2, 0);
        for (int k = 0; k < 40; k++)
            txn(1'($urandom), 2'($urandom), 11'($urandom), 1'($urandom), 2'($urandom),
                11'($urandom), int'($urandom_range(0, 17)), 1'($urandom));
        req_0 = 0; req_1 = 0; txn_done = 0;
        repeat (4) edge1();
        chk("drain", exp_q.size(), 0);
        chk("idle_end", {31'd0, bus_valid}, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
